// File: rtl/fir_tap_sequencer_if.sv
// Bundle of the sequencer's coefficient port, sample stream, ALU hookup and
// result stream. The slave side is the sequencer; the master side is the
// surrounding system, including the combinational MAC ALU that returns
// alu_sum_out.
interface fir_tap_sequencer_if #(
  parameter int AW = 7
);
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [15:0]   coef_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [15:0]   in_data;
  logic signed [15:0]   alu_x;
  logic signed [15:0]   alu_b;
  logic signed [38:0]   alu_sum_in;
  logic signed [38:0]   alu_sum_out;
  logic                 y_valid;
  logic                 y_ready;
  logic signed [38:0]   y_data;

  modport master (
    output coef_we, coef_addr, coef_data, in_valid, in_data, alu_sum_out, y_ready,
    input  in_ready, alu_x, alu_b, alu_sum_in, y_valid, y_data
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, in_valid, in_data, alu_sum_out, y_ready,
    output in_ready, alu_x, alu_b, alu_sum_in, y_valid, y_data
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: stores the last NTAPS samples in a circular delay line,
// walks every tap once per accepted sample through an external MAC ALU and
// holds the 39-bit result on a valid/ready output until it is consumed.
module fir_tap_sequencer #(
  parameter int NTAPS = 16,
  parameter int AW    = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  fir_tap_sequencer_if.slave bus
);
  // Narrowest index that addresses NTAPS entries.
  localparam int            IW     = $clog2(NTAPS);
  localparam logic [IW-1:0] LAST   = IW'(NTAPS - 1);
  // NTAPS reduced mod 2**IW; adding it back after an underflowing subtract
  // yields the index modulo NTAPS even when NTAPS is not a power of two.
  localparam logic [IW-1:0] NT_MOD = IW'(NTAPS);
  localparam logic [AW:0]   NT_AW  = (AW+1)'(NTAPS);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] delay_q [NTAPS];
  logic signed [15:0] coef_q  [NTAPS];
  logic [IW-1:0]      wr_ptr_q, newest_q, tap_q, rd_idx;
  logic signed [38:0] acc_q, y_data_q;
  logic               y_valid_q;
  logic               accept, coef_wr, last_tap;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  // Coefficients only change between passes; out-of-range addresses are dropped.
  assign coef_wr  = (state_q == IDLE) && bus.coef_we && ({1'b0, bus.coef_addr} < NT_AW);
  assign last_tap = (tap_q == LAST);
  // Tap k reads the sample k steps older than the newest one.
  assign rd_idx   = (newest_q >= tap_q) ? (newest_q - tap_q)
                                        : (newest_q - tap_q + NT_MOD);

  assign bus.in_ready = (state_q == IDLE);
  assign bus.y_valid  = y_valid_q;
  assign bus.y_data   = y_data_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and ALU operand drive (operands are zero outside MAC).
  always_comb begin
    state_d        = state_q;
    bus.alu_x      = '0;
    bus.alu_b      = '0;
    bus.alu_sum_in = '0;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = MAC;
      MAC: begin
        bus.alu_x      = delay_q[rd_idx];
        bus.alu_b      = coef_q[tap_q];
        bus.alu_sum_in = acc_q;
        if (last_tap) state_d = OUT;
      end
      OUT:     if (bus.y_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Delay line, coefficient store, pointers, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        delay_q[i] <= '0;
        coef_q[i]  <= '0;
      end
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
    end else begin
      if (coef_wr) coef_q[bus.coef_addr[IW-1:0]] <= bus.coef_data;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            delay_q[wr_ptr_q] <= bus.in_data;
            newest_q          <= wr_ptr_q;
            wr_ptr_q          <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            acc_q             <= '0;
            tap_q             <= '0;
          end
        end
        MAC: begin
          acc_q <= bus.alu_sum_out;
          if (last_tap) begin
            tap_q     <= '0;
            y_data_q  <= bus.alu_sum_out;
            y_valid_q <= 1'b1;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        OUT: if (bus.y_ready) y_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
